// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the 32 x 8 data memory.
// Each access runs IDLE/CAPTURE -> ISSUE -> CAPTURE, with done and read data returned on the edge leaving CAPTURE.
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              done_a,
  output logic              done_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t state_q, state_d;
  logic last_b_q, last_b_d;   // 1 when port B holds the most recent grant
  logic serv_b_q, serv_b_d;   // port of the access currently in flight
  logic op_we_q, op_we_d;
  logic gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic done_a_q, done_a_d, done_b_q, done_b_d;
  logic busy_q, busy_d;
  logic mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic take_a, take_b, arb_ok;

  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    serv_b_d    = serv_b_q;
    op_we_d     = op_we_q;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    done_a_d    = 1'b0;
    done_b_d    = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_a_d   = rdata_a_q;
    rdata_b_d   = rdata_b_q;

    // On contention the port that did not win last time goes first.
    take_a = req_a && (!req_b || last_b_q);
    take_b = req_b && (!req_a || !last_b_q);
    arb_ok = 1'b0;

    case (state_q)
      IDLE: begin
        arb_ok = 1'b1;
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        arb_ok  = 1'b1;
        state_d = IDLE;
        if (serv_b_q) begin
          done_b_d = 1'b1;
          if (!op_we_q) rdata_b_d = mem_rdata;
        end else begin
          done_a_d = 1'b1;
          if (!op_we_q) rdata_a_d = mem_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (arb_ok && (take_a || take_b)) begin
      state_d  = ISSUE;
      serv_b_d = take_b;
      last_b_d = take_b;
      mem_en_d = 1'b1;
      if (take_b) begin
        gnt_b_d     = 1'b1;
        op_we_d     = we_b;
        mem_we_d    = we_b;
        mem_addr_d  = addr_b;
        mem_wdata_d = wdata_b;
      end else begin
        gnt_a_d     = 1'b1;
        op_we_d     = we_a;
        mem_we_d    = we_a;
        mem_addr_d  = addr_a;
        mem_wdata_d = wdata_a;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      serv_b_q    <= 1'b0;
      op_we_q     <= 1'b0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      done_a_q    <= 1'b0;
      done_b_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      serv_b_q    <= serv_b_d;
      op_we_q     <= op_we_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      done_a_q    <= done_a_d;
      done_b_q    <= done_b_d;
      busy_q      <= busy_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign done_a    = done_a_q;
  assign done_b    = done_b_q;
  assign rdata_a   = rdata_a_q;
  assign rdata_b   = rdata_b_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a 32 x 8 synchronous memory model attached.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic       we_a = 1'b0, we_b = 1'b0;
  logic [4:0] addr_a = '0, addr_b = '0;
  logic [7:0] wdata_a = '0, wdata_b = '0;
  logic       gnt_a, gnt_b, done_a, done_b, busy, mem_en, mem_we;
  logic [7:0] rdata_a, rdata_b, mem_wdata, mem_rdata;
  logic [4:0] mem_addr;

  int n_chk = 0;
  int n_pass = 0;

  logic       exp_gnt[$];     // 0 = A, 1 = B, in grant order
  logic [7:0] exp_rd_a[$];
  logic [7:0] exp_rd_b[$];

  logic [7:0] mem [32];
  logic [7:0] mem_rd_r = '0;

  mem_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'h3C;
    mem[1] = 8'h21;
    mem[2] = 8'h42;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rd_r <= mem[mem_addr];
    end
  end
  assign mem_rdata = mem_rd_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: every grant and every done is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt_a || gnt_b) begin
        if (exp_gnt.size() == 0) chk("gnt_unexpected", {gnt_a, gnt_b}, 0);
        else chk("gnt_port", {31'd0, gnt_b}, {31'd0, exp_gnt.pop_front()});
      end
      if (done_a) begin
        if (exp_rd_a.size() == 0) chk("done_a_unexpected", 1, 0);
        else chk("sb_rdata_a", rdata_a, exp_rd_a.pop_front());
      end
      if (done_b) begin
        if (exp_rd_b.size() == 0) chk("done_b_unexpected", 1, 0);
        else chk("sb_rdata_b", rdata_b, exp_rd_b.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic p, input logic v, input logic w, input logic [4:0] a, input logic [7:0] d);
    if (p) begin req_b = v; we_b = w; addr_b = a; wdata_b = d; end
    else   begin req_a = v; we_a = w; addr_a = a; wdata_a = d; end
  endtask

  function automatic logic gnt_of(input logic p);
    return p ? gnt_b : gnt_a;
  endfunction

  function automatic logic done_of(input logic p);
    return p ? done_b : done_a;
  endfunction

  // Isolated access from IDLE: gnt in cycle 1, done in cycle 3.
  task automatic single(input logic p, input logic w, input logic [4:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
    exp_gnt.push_back(p);
    if (p) exp_rd_b.push_back(exp_rd); else exp_rd_a.push_back(exp_rd);
    set_req(p, 1'b1, w, a, d);
    tick();
    chk("single_gnt", gnt_of(p), 1);
    chk("single_mem_en", mem_en, 1);
    chk("single_mem_we", mem_we, w);
    chk("single_mem_addr", mem_addr, a);
    if (w) chk("single_mem_wdata", mem_wdata, d);
    set_req(p, 1'b0, 1'b0, 5'd0, 8'd0);
    tick();
    chk("single_capture_en", mem_en, 0);
    chk("single_capture_busy", busy, 1);
    tick();
    chk("single_done", done_of(p), 1);
    chk("single_rdata", p ? rdata_b : rdata_a, exp_rd);
    chk("single_idle", busy, 0);
  endtask

  // Simultaneous requests from IDLE; first_b selects who should win.
  task automatic contend(input logic first_b,
                         input logic wa, input logic [4:0] aa, input logic [7:0] da, input logic [7:0] ea,
                         input logic wb, input logic [4:0] ab, input logic [7:0] db, input logic [7:0] eb);
    exp_gnt.push_back(first_b);
    exp_gnt.push_back(!first_b);
    exp_rd_a.push_back(ea);
    exp_rd_b.push_back(eb);
    set_req(1'b0, 1'b1, wa, aa, da);
    set_req(1'b1, 1'b1, wb, ab, db);
    tick();
    chk("cont_gnt_first", gnt_of(first_b), 1);
    chk("cont_no_gnt_second", gnt_of(!first_b), 0);
    if (first_b) set_req(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
    else         set_req(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    tick();
    tick();
    chk("cont_done_first", done_of(first_b), 1);
    chk("cont_gnt_second", gnt_of(!first_b), 1);
    if (first_b) set_req(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    else         set_req(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
    tick();
    tick();
    chk("cont_done_second", done_of(!first_b), 1);
    chk("cont_idle", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_gnt", {gnt_a, gnt_b}, 0);
    chk("rst_done", {done_a, done_b}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", {rdata_a, rdata_b}, 0);
    rst_n = 1'b1;
    tick();

    // Port B write then read
    single(1'b1, 1'b1, 5'd3, 8'h5A, 8'h00);
    single(1'b1, 1'b0, 5'd3, 8'h00, 8'h5A);

    // Contention after reset: A first, twice
    contend(1'b0, 1'b0, 5'd3, 8'h00, 8'h5A, 1'b1, 5'd7, 8'h11, 8'h5A);
    contend(1'b0, 1'b0, 5'd7, 8'h00, 8'h11, 1'b0, 5'd1, 8'h00, 8'h21);

    // After an A-only access, contention favours B
    single(1'b0, 1'b0, 5'd2, 8'h00, 8'h42);
    contend(1'b1, 1'b0, 5'd0, 8'h00, 8'h3C, 1'b0, 5'd2, 8'h00, 8'h42);

    // Back-to-back reads of 0, 1, 2 on port A
    exp_gnt.push_back(1'b0); exp_gnt.push_back(1'b0); exp_gnt.push_back(1'b0);
    exp_rd_a.push_back(8'h3C); exp_rd_a.push_back(8'h21); exp_rd_a.push_back(8'h42);
    set_req(1'b0, 1'b1, 1'b0, 5'd0, 8'd0);
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk("b2b_gnt", gnt_a, ((c % 2 == 1) && c <= 5) ? 1 : 0);
      chk("b2b_busy", busy, (c <= 6) ? 1 : 0);
      if (c == 3 || c == 5 || c == 7) chk("b2b_done", done_a, 1);
      if (c == 1) addr_a = 5'd1;
      if (c == 3) addr_a = 5'd2;
      if (c == 5) req_a = 1'b0;
    end
    chk("b2b_rdata_last", rdata_a, 8'h42);

    // Boundary address 31
    single(1'b0, 1'b1, 5'd31, 8'hFF, 8'h42);
    single(1'b0, 1'b0, 5'd31, 8'h00, 8'hFF);
    single(1'b0, 1'b0, 5'd0, 8'h00, 8'h3C);

    // Reset during CAPTURE of a port A read
    exp_gnt.push_back(1'b0);
    set_req(1'b0, 1'b1, 1'b0, 5'd1, 8'd0);
    tick();
    chk("rmid_gnt", gnt_a, 1);
    set_req(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rmid_rdata_a", rdata_a, 0);
    chk("rmid_rdata_b", rdata_b, 0);
    chk("rmid_busy", busy, 0);
    tick();
    chk("rmid_no_done", {done_a, done_b}, 0);
    rst_n = 1'b1;
    tick();
    contend(1'b0, 1'b0, 5'd1, 8'h00, 8'h21, 1'b0, 5'd31, 8'h00, 8'hFF);

    // Held request on port A repeats the access every 2 cycles
    for (int k = 0; k < 4; k++) begin
      exp_gnt.push_back(1'b0);
      exp_rd_a.push_back(8'h42);
    end
    set_req(1'b0, 1'b1, 1'b0, 5'd2, 8'd0);
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk("held_gnt", gnt_a, ((c % 2 == 1) && c <= 7) ? 1 : 0);
      chk("held_done", done_a, ((c % 2 == 1) && c >= 3) ? 1 : 0);
      if (c == 7) req_a = 1'b0;
    end
    chk("held_idle", busy, 0);

    tick();
    tick();
    chk("sb_gnt_empty", exp_gnt.size(), 0);
    chk("sb_a_empty", exp_rd_a.size(), 0);
    chk("sb_b_empty", exp_rd_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the 32 x 8 data memory. It shares the single memory port between the instruction-fetch requester (port A) and the load/store requester (port B). It uses a registered req/gnt/done handshake, round-robin arbitration on contention, and a fixed issue/capture sequence toward a synchronous memory with one-cycle read latency. The block sits between the control unit and the memory array; every memory access in the processor passes through it.

## Interface
- ADDR_W, 5, memory address width (32 words)
- DATA_W, 8, memory word width
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_a / req_b  in  1  access request, port A / port B
- we_a / we_b  in  1  1 = write, 0 = read
- addr_a / addr_b  in  ADDR_W  word address
- wdata_a / wdata_b  in  DATA_W  write data
- gnt_a / gnt_b  out  1  one-cycle pulse; the request has been issued to memory
- done_a / done_b  out  1  one-cycle pulse; the access is complete
- rdata_a / rdata_b  out  DATA_W  read result, held until the next read completes on that port
- busy  out  1  high whenever state is not IDLE
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable, valid only while mem_en is high
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in the cycle after mem_en with mem_we low

## Operation
- States:
  - IDLE: no access in progress.
  - ISSUE: mem_en = 1, mem_we / mem_addr / mem_wdata driven from latched request; the granted gnt_x = 1.
  - CAPTURE: mem_en = 0; mem_rdata is valid in this cycle.
- Arbitration happens on the clock edge that leaves IDLE or CAPTURE, using the req_x values sampled at that edge.
  - Only one req high: grant that port.
  - Both high: grant the port not granted last (round-robin via a last_grant register).
  - Neither high: go to IDLE.
- On a grant, we_x, addr_x and wdata_x are latched at the same edge. Requester inputs may change freely after that edge.
- Transitions:
  - IDLE to ISSUE on a grant.
  - ISSUE always goes to CAPTURE.
  - CAPTURE to ISSUE on a new grant, otherwise to IDLE.
- At the edge leaving CAPTURE:
  - Reads: rdata_x of the port being serviced is loaded from mem_rdata.
  - Reads and writes: done_x is set for exactly one cycle.
- Writes leave rdata_x unchanged.
- Handshake rule: a requester drops req_x in the cycle after it sees gnt_x (the CAPTURE cycle). If req_x is still high when sampled in CAPTURE, it is a new request.
- Addresses are used unmodified; there is no increment, so there is no wrap. Address 31 is a legal word.
- Ports A and B are independent. One port's done_x and the other port's gnt_x may be high in the same cycle.

## Timing
- Reset (asynchronous, immediate) sets:
  - state = IDLE, last_grant = B (so A wins the first contention).
  - All gnt_x, done_x, busy, mem_en and mem_we = 0.
  - mem_addr, mem_wdata, rdata_a and rdata_b = 0.
- Reset mid-access abandons the access: no done_x, and rdata_x is cleared. A write issued in that same cycle is not guaranteed.
- Isolated access, req_x first high in cycle 0 while IDLE:
  - Cycle 1: ISSUE, gnt_x = 1.
  - Cycle 2: CAPTURE.
  - Cycle 3: done_x = 1, rdata_x valid.
  - Request-to-done latency = 3 cycles.
- Back-to-back: a request sampled in CAPTURE goes straight to ISSUE. Sustained throughput is 1 access per 2 cycles. done_x of the previous access coincides with gnt of the next.
- Under continuous dual requests, grants alternate A, B, A, B. No port waits more than one access.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Write then read, port B:
  - Write 0x5A to address 3. Expect gnt_b in cycle 1, mem_en = 1 with mem_we = 1 in cycle 1, done_b in cycle 3, rdata_b = 0 unchanged.
  - Then read address 3. Expect rdata_b = 0x5A together with done_b.
- Contention from reset, req_a and req_b high in the same cycle:
  - A is granted first, B is granted at the next ISSUE.
  - A second simultaneous pair is granted A then B again.
- Back-to-back on port A: reads of addresses 0, 1, 2 issued whenever gnt allows. Expect gnt_a every 2 cycles and busy continuously high.
- Boundary address: write 0xFF to address 31, then read it back. Expect 0xFF, and address 0 unaffected.
- Reset mid-access: assert rst_n = 0 during CAPTURE of a port A read. Expect no done_a, rdata_a = 0, state IDLE, and the next contention granted to A.
- Held request: keep req_a high for 6 cycles after gnt_a. Expect a repeated access (a second gnt_a 2 cycles after the first).
